mem_wb_stage: RTL and testbench

- Consumer end of the execute-stage result interface: takes one execute result per cycle and completes it.
- Completion means a data-memory access, register writeback, a PC redirect to fetch, or halt.
- Owns the data-memory req/ack handshake and back-pressures execute via stall_o.
- Sits between superExecute and the integer/vector register files and the fetch stage.

---
 rtl/mem_wb_stage.sv | 149 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: completes one execute result per cycle as a memory access, register writeback, PC redirect or halt.
// Optional build macro MEMWB_TIMEOUT_EN: abort a memory wait after TIMEOUT_CYCLES cycles without ack and raise err_o.
module mem_wb_stage #(
    parameter int REGI_BITS      = 4,
    parameter int REGI_SIZE      = 16,
    parameter int VECT_SIZE      = 8,
    parameter int ELEM_SIZE      = 8,
    parameter int MEMO_LINES     = 64,
    parameter int TIMEOUT_CYCLES = 16,
    localparam int AW            = $clog2(MEMO_LINES),
    localparam int VW            = ELEM_SIZE * VECT_SIZE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [REGI_SIZE-1:0] int_res_i,
    input  logic [VW-1:0]        vec_res_i,
    input  logic                 is_vec_i,
    input  logic [REGI_BITS-1:0] dest_i,
    input  logic                 enableReg_i,
    input  logic                 enableMem_i,
    input  logic                 flagMemRead_i,
    input  logic                 flagMemWrite_i,
    input  logic                 enableJump_i,
    input  logic [9:0]           jumpAddress_i,
    input  logic                 flagEnd_i,
    output logic                 stall_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [VW-1:0]        mem_wdata_o,
    input  logic                 mem_ack_i,
    input  logic [VW-1:0]        mem_rdata_i,
    output logic                 int_we_o,
    output logic                 vec_we_o,
    output logic [REGI_BITS-1:0] wb_addr_o,
    output logic [REGI_SIZE-1:0] int_wd_o,
    output logic [VW-1:0]        vec_wd_o,
    output logic                 pc_load_o,
    output logic [REGI_SIZE-1:0] pc_target_o,
    output logic                 halt_o,
    output logic                 err_o
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t               state, stateNext;
    logic                 accept;
    logic                 isMemOp;
    logic                 timeoutHit;
    logic                 pendLoad;
    logic [REGI_BITS-1:0] pendDest;

    assign accept  = valid_i && (state == IDLE) && !halt_o;
    // A memory op with neither direction flag carries no access and completes like an ALU op.
    assign isMemOp = enableMem_i && (flagMemRead_i || flagMemWrite_i);

`ifdef MEMWB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] waitCnt;

    always_ff @(posedge clk_i) begin
        if (rst_i || state != WAIT) waitCnt <= '0;
        else                        waitCnt <= waitCnt + 1'b1;
    end

    // An ack in the final permitted cycle still wins over the abort.
    assign timeoutHit = (state == WAIT) && !mem_ack_i &&
                        (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    // No abort path in this build; the parameter stays for interface compatibility.
    assign timeoutHit = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (accept && isMemOp)      stateNext = WAIT;
            WAIT: if (mem_ack_i || timeoutHit) stateNext = IDLE;
            default:                          stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            stall_o     <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            int_we_o    <= 1'b0;
            vec_we_o    <= 1'b0;
            wb_addr_o   <= '0;
            int_wd_o    <= '0;
            vec_wd_o    <= '0;
            pc_load_o   <= 1'b0;
            pc_target_o <= '0;
            halt_o      <= 1'b0;
            err_o       <= 1'b0;
            pendLoad    <= 1'b0;
            pendDest    <= '0;
        end else begin
            state     <= stateNext;
            stall_o   <= (stateNext == WAIT);
            int_we_o  <= 1'b0;
            vec_we_o  <= 1'b0;
            pc_load_o <= 1'b0;

            if (accept) begin
                if (isMemOp) begin
                    mem_req_o   <= 1'b1;
                    mem_we_o    <= flagMemWrite_i;
                    mem_addr_o  <= int_res_i[AW-1:0];
                    mem_wdata_o <= vec_res_i;
                    pendLoad    <= flagMemRead_i && !flagMemWrite_i;
                    pendDest    <= dest_i;
                    if (flagMemRead_i && flagMemWrite_i) err_o <= 1'b1;
                end else if (enableReg_i) begin
                    int_we_o  <= !is_vec_i;
                    vec_we_o  <= is_vec_i;
                    wb_addr_o <= dest_i;
                    if (is_vec_i) vec_wd_o <= vec_res_i;
                    else          int_wd_o <= int_res_i;
                end
                if (enableJump_i) begin
                    pc_load_o   <= 1'b1;
                    pc_target_o <= REGI_SIZE'(jumpAddress_i);
                end
                if (flagEnd_i) halt_o <= 1'b1;
            end

            if (state == WAIT) begin
                if (mem_ack_i) begin
                    mem_req_o <= 1'b0;
                    if (pendLoad) begin
                        vec_we_o  <= 1'b1;
                        vec_wd_o  <= mem_rdata_i;
                        wb_addr_o <= pendDest;
                    end
                end else if (timeoutHit) begin
                    mem_req_o <= 1'b0;
                    err_o     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: randomized ops compared against expectations derived from the stage's completion rules.
module tb_mem_wb_stage;

    localparam int REGI_BITS = 4;
    localparam int REGI_SIZE = 16;
    localparam int VW        = 64;
    localparam int LINES     = 64;
    localparam int TOUT      = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_i, valid_i, is_vec_i, enableReg_i, enableMem_i;
    logic                 flagMemRead_i, flagMemWrite_i, enableJump_i, flagEnd_i, mem_ack_i;
    logic [REGI_SIZE-1:0] int_res_i;
    logic [VW-1:0]        vec_res_i, mem_rdata_i;
    logic [REGI_BITS-1:0] dest_i;
    logic [9:0]           jumpAddress_i;
    logic                 stall_o, mem_req_o, mem_we_o, int_we_o, vec_we_o, pc_load_o, halt_o, err_o;
    logic [5:0]           mem_addr_o;
    logic [VW-1:0]        mem_wdata_o, vec_wd_o;
    logic [REGI_BITS-1:0] wb_addr_o;
    logic [REGI_SIZE-1:0] int_wd_o, pc_target_o;

    int nTests = 0;
    int nFail  = 0;

    mem_wb_stage #(.REGI_BITS(REGI_BITS), .REGI_SIZE(REGI_SIZE), .VECT_SIZE(8), .ELEM_SIZE(8),
                   .MEMO_LINES(LINES), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .int_res_i(int_res_i), .vec_res_i(vec_res_i),
        .is_vec_i(is_vec_i), .dest_i(dest_i), .enableReg_i(enableReg_i), .enableMem_i(enableMem_i),
        .flagMemRead_i(flagMemRead_i), .flagMemWrite_i(flagMemWrite_i), .enableJump_i(enableJump_i),
        .jumpAddress_i(jumpAddress_i), .flagEnd_i(flagEnd_i), .stall_o(stall_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
        .mem_rdata_i(mem_rdata_i), .int_we_o(int_we_o), .vec_we_o(vec_we_o), .wb_addr_o(wb_addr_o),
        .int_wd_o(int_wd_o), .vec_wd_o(vec_wd_o), .pc_load_o(pc_load_o), .pc_target_o(pc_target_o),
        .halt_o(halt_o), .err_o(err_o)
    );

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clearIn();
        valid_i = 0; is_vec_i = 0; enableReg_i = 0; enableMem_i = 0; flagMemRead_i = 0;
        flagMemWrite_i = 0; enableJump_i = 0; flagEnd_i = 0; mem_ack_i = 0;
        int_res_i = '0; vec_res_i = '0; mem_rdata_i = '0; dest_i = '0; jumpAddress_i = '0;
    endtask

    task automatic doReset();
        clearIn(); rst_i = 1; tick(); tick(); rst_i = 0;
    endtask

    task automatic junkIn();
        valid_i = 1; enableReg_i = 1; enableJump_i = 1; is_vec_i = 1'($urandom);
        enableMem_i = 1'($urandom); flagMemRead_i = 1'($urandom); flagMemWrite_i = 1'($urandom);
        dest_i = 4'($urandom); int_res_i = 16'($urandom); vec_res_i = {$urandom, $urandom};
    endtask

    task automatic test_reset();
        clearIn(); rst_i = 1; junkIn(); mem_ack_i = 1; mem_rdata_i = {$urandom, $urandom};
        tick(); tick();
        nTests++;
        if ({stall_o, mem_req_o, mem_we_o, int_we_o, vec_we_o, pc_load_o, halt_o, err_o} !== 8'h00) begin
            nFail++; $display("FAIL reset_ctrl got=%b exp=00000000",
                {stall_o, mem_req_o, mem_we_o, int_we_o, vec_we_o, pc_load_o, halt_o, err_o});
        end
        nTests++;
        if ({mem_addr_o, mem_wdata_o, wb_addr_o, int_wd_o, vec_wd_o, pc_target_o} !== '0) begin
            nFail++; $display("FAIL reset_data got addr=%h wd=%h wb=%h iwd=%h vwd=%h pc=%h exp=all 0",
                mem_addr_o, mem_wdata_o, wb_addr_o, int_wd_o, vec_wd_o, pc_target_o);
        end
        rst_i = 0; clearIn(); mem_ack_i = 1; mem_rdata_i = {$urandom, $urandom};
        tick(); clearIn();
        nTests++;
        if ({mem_req_o, vec_we_o, stall_o} !== 3'b000) begin
            nFail++; $display("FAIL idle_ack got=%b exp=000", {mem_req_o, vec_we_o, stall_o});
        end
    endtask

    task automatic test_nonmem();
        logic eI, eV, eJ;
        logic [REGI_BITS-1:0] eDest;
        logic [REGI_SIZE-1:0] eInt, ePc;
        logic [VW-1:0]        eVec;
        doReset();
        for (int i = 0; i <= 30; i++) begin
            clearIn();
            if (i < 30) begin
                valid_i = ($urandom_range(0, 4) != 0); is_vec_i = 1'($urandom); enableReg_i = 1'($urandom);
                enableMem_i = ($urandom_range(0, 3) == 0); enableJump_i = 1'($urandom);
                jumpAddress_i = 10'($urandom); dest_i = 4'($urandom);
                int_res_i = 16'($urandom); vec_res_i = {$urandom, $urandom};
                if (i == 0) begin
                    valid_i = 1; is_vec_i = 0; enableReg_i = 1; enableMem_i = 0; enableJump_i = 0;
                    dest_i = 4'd3; int_res_i = 16'h00A5;
                end
            end
            eI = valid_i && enableReg_i && !is_vec_i;
            eV = valid_i && enableReg_i && is_vec_i;
            eJ = valid_i && enableJump_i;
            eDest = dest_i; eInt = int_res_i; eVec = vec_res_i; ePc = {6'b0, jumpAddress_i};
            tick();
            nTests++;
            if ({int_we_o, vec_we_o, pc_load_o, mem_req_o, stall_o} !== {eI, eV, eJ, 2'b00}) begin
                nFail++; $display("FAIL nonmem_strobes[%0d] got=%b exp=%b", i,
                    {int_we_o, vec_we_o, pc_load_o, mem_req_o, stall_o}, {eI, eV, eJ, 2'b00});
            end
            if (eI) begin
                nTests++;
                if ({wb_addr_o, int_wd_o} !== {eDest, eInt}) begin
                    nFail++; $display("FAIL nonmem_int[%0d] got=%h/%h exp=%h/%h", i, wb_addr_o, int_wd_o, eDest, eInt);
                end
            end
            if (eV) begin
                nTests++;
                if ({wb_addr_o, vec_wd_o} !== {eDest, eVec}) begin
                    nFail++; $display("FAIL nonmem_vec[%0d] got=%h/%h exp=%h/%h", i, wb_addr_o, vec_wd_o, eDest, eVec);
                end
            end
            if (eJ) begin
                nTests++;
                if (pc_target_o !== ePc) begin
                    nFail++; $display("FAIL nonmem_pc[%0d] got=%h exp=%h", i, pc_target_o, ePc);
                end
            end
        end
    endtask

    task automatic test_memory();
        logic                 isSt;
        logic [REGI_SIZE-1:0] addr, bInt;
        logic [5:0]           eAddr;
        logic [VW-1:0]        wd, rd;
        logic [REGI_BITS-1:0] dest, bDest;
        int                   d;
        doReset();
        for (int i = 0; i < 14; i++) begin
            isSt = (i == 1) ? 1'b1 : (i == 0) ? 1'b0 : 1'($urandom);
            addr = (i == 0) ? 16'h0007 : (i == 1) ? 16'd12 : 16'($urandom);
            wd   = (i == 1) ? 64'hFFEEDDCCBBAA9900 : {$urandom, $urandom};
            rd   = (i == 0) ? 64'h0102030405060708 : {$urandom, $urandom};
            d    = (i == 0) ? 3 : (i == 1) ? 1 : int'($urandom_range(1, 5));
            dest = 4'($urandom);
            eAddr = 6'(addr % LINES);
            clearIn(); valid_i = 1; enableMem_i = 1; flagMemRead_i = !isSt; flagMemWrite_i = isSt;
            int_res_i = addr; vec_res_i = wd; dest_i = dest; enableReg_i = 1'($urandom); is_vec_i = 1'($urandom);
            tick();
            clearIn();
            nTests++;
            if ({mem_req_o, mem_we_o, stall_o, int_we_o, vec_we_o, mem_addr_o, mem_wdata_o} !==
                {1'b1, isSt, 1'b1, 2'b00, eAddr, wd}) begin
                nFail++; $display("FAIL mem_issue[%0d] got req=%b we=%b st=%b iwe=%b vwe=%b a=%h wd=%h exp we=%b a=%h wd=%h",
                    i, mem_req_o, mem_we_o, stall_o, int_we_o, vec_we_o, mem_addr_o, mem_wdata_o, isSt, eAddr, wd);
            end
            for (int k = 1; k < d; k++) begin
                junkIn(); tick();
                nTests++;
                if ({mem_req_o, mem_we_o, stall_o, int_we_o, vec_we_o, pc_load_o, mem_addr_o, mem_wdata_o} !==
                    {1'b1, isSt, 1'b1, 3'b000, eAddr, wd}) begin
                    nFail++; $display("FAIL mem_wait[%0d.%0d] got req=%b we=%b st=%b strobes=%b a=%h exp a=%h", i, k,
                        mem_req_o, mem_we_o, stall_o, {int_we_o, vec_we_o, pc_load_o}, mem_addr_o, eAddr);
                end
            end
            junkIn(); mem_ack_i = 1; mem_rdata_i = rd;
            tick();
            clearIn(); mem_rdata_i = {$urandom, $urandom};
            nTests++;
            if ({mem_req_o, stall_o, int_we_o, pc_load_o, vec_we_o} !== {4'b0000, !isSt}) begin
                nFail++; $display("FAIL mem_done[%0d] got=%b exp=%b", i,
                    {mem_req_o, stall_o, int_we_o, pc_load_o, vec_we_o}, {4'b0000, !isSt});
            end
            if (!isSt) begin
                nTests++;
                if ({wb_addr_o, vec_wd_o} !== {dest, rd}) begin
                    nFail++; $display("FAIL load_wb[%0d] got=%h/%h exp=%h/%h", i, wb_addr_o, vec_wd_o, dest, rd);
                end
            end
            bDest = 4'($urandom); bInt = 16'($urandom);
            valid_i = 1; enableReg_i = 1; dest_i = bDest; int_res_i = bInt;
            tick();
            clearIn();
            nTests++;
            if ({int_we_o, vec_we_o, mem_req_o, wb_addr_o, int_wd_o} !== {3'b100, bDest, bInt}) begin
                nFail++; $display("FAIL back_to_back[%0d] got=%b %h %h exp=100 %h %h", i,
                    {int_we_o, vec_we_o, mem_req_o}, wb_addr_o, int_wd_o, bDest, bInt);
            end
        end
        nTests++;
        if (err_o !== 1'b0) begin
            nFail++; $display("FAIL mem_err got=%b exp=0", err_o);
        end
    endtask

    task automatic test_jump_halt();
        doReset();
        valid_i = 1; enableJump_i = 1; jumpAddress_i = 10'h3FF; enableReg_i = 1; dest_i = 4'd5; int_res_i = 16'h1234;
        tick(); clearIn();
        nTests++;
        if ({pc_load_o, pc_target_o, int_we_o, wb_addr_o, int_wd_o, halt_o} !== {1'b1, 16'h03FF, 1'b1, 4'd5, 16'h1234, 1'b0}) begin
            nFail++; $display("FAIL jump got ld=%b pc=%h iwe=%b wb=%h d=%h halt=%b exp 1 03ff 1 5 1234 0",
                pc_load_o, pc_target_o, int_we_o, wb_addr_o, int_wd_o, halt_o);
        end
        valid_i = 1; flagEnd_i = 1;
        tick(); clearIn();
        nTests++;
        if ({halt_o, pc_load_o, int_we_o} !== 3'b100) begin
            nFail++; $display("FAIL halt_set got=%b exp=100", {halt_o, pc_load_o, int_we_o});
        end
        for (int i = 0; i < 6; i++) begin
            junkIn(); enableMem_i = 1; flagMemRead_i = 1;
            tick();
            nTests++;
            if ({halt_o, pc_load_o, int_we_o, vec_we_o, mem_req_o, stall_o} !== 6'b100000) begin
                nFail++; $display("FAIL halted[%0d] got=%b exp=100000", i,
                    {halt_o, pc_load_o, int_we_o, vec_we_o, mem_req_o, stall_o});
            end
        end
        clearIn();
    endtask

    task automatic test_reset_mid_wait();
        doReset();
        valid_i = 1; enableMem_i = 1; flagMemRead_i = 1; int_res_i = 16'd9; dest_i = 4'd2;
        tick(); clearIn();
        nTests++;
        if (mem_req_o !== 1'b1) begin
            nFail++; $display("FAIL rstwait_req got=%b exp=1", mem_req_o);
        end
        rst_i = 1; tick(); rst_i = 0;
        nTests++;
        if ({stall_o, mem_req_o, mem_we_o, int_we_o, vec_we_o, pc_load_o, halt_o, err_o, mem_addr_o} !== '0) begin
            nFail++; $display("FAIL rstwait_outs got=%b addr=%h exp=all 0",
                {stall_o, mem_req_o, mem_we_o, int_we_o, vec_we_o, pc_load_o, halt_o, err_o}, mem_addr_o);
        end
        mem_ack_i = 1; mem_rdata_i = {$urandom, $urandom};
        tick(); clearIn();
        nTests++;
        if ({mem_req_o, vec_we_o, stall_o} !== 3'b000) begin
            nFail++; $display("FAIL rstwait_late_ack got=%b exp=000", {mem_req_o, vec_we_o, stall_o});
        end
    endtask

    task automatic test_both_flags();
        logic [VW-1:0] wd;
        doReset();
        wd = {$urandom, $urandom};
        valid_i = 1; enableMem_i = 1; flagMemRead_i = 1; flagMemWrite_i = 1; int_res_i = 16'd33;
        vec_res_i = wd; dest_i = 4'd6; enableReg_i = 1;
        tick(); clearIn();
        nTests++;
        if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, 6'd33, wd}) begin
            nFail++; $display("FAIL both_issue got req=%b we=%b a=%h wd=%h exp 1 1 21 %h",
                mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, wd);
        end
        mem_ack_i = 1; mem_rdata_i = {$urandom, $urandom};
        tick(); clearIn();
        nTests++;
        if ({mem_req_o, vec_we_o, int_we_o, err_o} !== 4'b0001) begin
            nFail++; $display("FAIL both_done got=%b exp=0001", {mem_req_o, vec_we_o, int_we_o, err_o});
        end
        tick();
        nTests++;
        if (err_o !== 1'b1) begin
            nFail++; $display("FAIL err_sticky got=%b exp=1", err_o);
        end
    endtask

    task automatic test_wait_limit();
        doReset();
        valid_i = 1; enableMem_i = 1; flagMemRead_i = 1; int_res_i = 16'd4; dest_i = 4'd1;
        tick(); clearIn();
`ifdef MEMWB_TIMEOUT_EN
        for (int k = 1; k < TOUT; k++) begin
            tick();
            nTests++;
            if ({mem_req_o, stall_o, err_o} !== 3'b110) begin
                nFail++; $display("FAIL timeout_wait[%0d] got=%b exp=110", k, {mem_req_o, stall_o, err_o});
            end
        end
        tick();
        nTests++;
        if ({mem_req_o, stall_o, vec_we_o, err_o} !== 4'b0001) begin
            nFail++; $display("FAIL timeout_abort got=%b exp=0001", {mem_req_o, stall_o, vec_we_o, err_o});
        end
`else
        for (int k = 1; k < 3 * TOUT; k++) tick();
        nTests++;
        if ({mem_req_o, stall_o, err_o} !== 3'b110) begin
            nFail++; $display("FAIL long_wait got=%b exp=110", {mem_req_o, stall_o, err_o});
        end
        mem_ack_i = 1; mem_rdata_i = 64'hA5A5_5A5A_0F0F_F0F0;
        tick(); clearIn();
        nTests++;
        if ({mem_req_o, vec_we_o, wb_addr_o, vec_wd_o} !== {2'b01, 4'd1, 64'hA5A5_5A5A_0F0F_F0F0}) begin
            nFail++; $display("FAIL long_wait_done got=%b wb=%h d=%h exp 01 1 a5a55a5a0f0ff0f0",
                {mem_req_o, vec_we_o}, wb_addr_o, vec_wd_o);
        end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired tests=%0d", nTests);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1;
        clearIn();
        test_reset();
        test_nonmem();
        test_memory();
        test_jump_halt();
        test_reset_mid_wait();
        test_both_flags();
        test_wait_limit();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
